// File: rtl/dmem_bytelane.sv
// Single-port byte-lane data memory with valid/ready request/response and READ_LAT-cycle response.
// Define DMEM_MISALIGN_CHK_EN to flag misaligned half/word accesses as errors.
module dmem_bytelane #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_LAST = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic          bad_q, bad_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        in_range;
  logic        misalign;
  logic        req_bad;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic [31:0] word_rd;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign in_range  = ~|req_addr[31:AW+2];

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_bad = !in_range || (req_size == 2'b11) || misalign;

  always_comb begin
    be     = 4'b0000;
    wlanes = req_wdata;
    case (req_size)
      2'b00: begin
        be     = 4'b0001 << req_addr[1:0];
        wlanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be     = req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Stores commit on the accept edge so any later load observes them.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_bad) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[req_addr[AW+1:2]][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign word_rd  = mem[idx_q];
  assign byte_sel = word_rd[{lane_q, 3'b000} +: 8];
  assign half_sel = lane_q[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    case (size_q)
      2'b00:   load_data = {{24{!uns_q && byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{!uns_q && half_sel[15]}}, half_sel};
      default: load_data = word_rd;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    bad_d       = bad_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          idx_d   = req_addr[AW+1:2];
          lane_d  = req_addr[1:0];
          bad_d   = req_bad;
          cnt_d   = '0;
          state_d = (READ_LAT == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_LAST) state_d = RESP;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      RESP: begin
        // First RESP cycle registers the result; rsp_valid rises READ_LAT edges after accept.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (we_q || bad_q) ? '0 : load_data;
          rsp_err_d   = bad_q;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      idx_q       <= '0;
      lane_q      <= '0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      bad_q       <= bad_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
